change_dispenser: RTL and testbench
===================================

# change_dispenser

Sequences physical change return for the vending machine once a sale completes. It takes the change amount produced by the calculation datapath and pays it out greedily in coin denominations 10, 5, 2 and 1, drawing from a per-denomination coin inventory. Each coin is ejected as a timed pulse paced by an external tick strobe, such as the 1 s divider output. It reports busy/done and flags a shortfall when inventory cannot cover the full amount.

## Interface
Parameters:
- PULSE_TICKS, default 2: number of tick strobes each eject output stays high (≥1).
- GAP_TICKS, default 1: number of tick strobes of idle gap after each coin (≥1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- tick  in  1  one-cycle pacing strobe.
- start  in  1  one-cycle request to pay `amount`.
- amount  in  7  change to pay, 0..127.
- refill  in  1  one-cycle pulse that loads all inventories.
- inv10_in, inv5_in, inv2_in, inv1_in  in  4 each  refill values.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- short  out  1  the last request could not be fully paid. Held until the next accepted start.
- remaining  out  7  amount still unpaid.
- eject10, eject5, eject2, eject1  out  1 each  coin release pulses. At most one is high at a time.
- inv10, inv5, inv2, inv1  out  4 each  current inventory counts.

## Operation
- The FSM has five states: IDLE, SELECT, PULSE, GAP, DONE.
- IDLE:
  - refill loads all four inventories from the inv*_in inputs.
  - If start is high in the same cycle as refill, refill wins and start is dropped.
  - start (without refill) does the following: latch remaining←amount and clear short. Go to DONE if amount==0, otherwise go to SELECT.
- SELECT (exactly one cycle; tick is ignored):
  - Pick the largest denomination d in the order 10, 5, 2, 1 such that d ≤ remaining and inv_d > 0.
  - If a d is found: latch it as sel, decrement inv_d, set remaining ← remaining − d, clear the tick counter, go to PULSE.
  - If no d is found: set short←1 and go to DONE. remaining keeps the unpaid value.
- PULSE: eject_sel is high for the whole state. Each tick increments the counter. On the tick that makes count == PULSE_TICKS−1, clear the counter and go to GAP.
- GAP: all eject outputs are low. On the tick that makes count == GAP_TICKS−1, go to DONE if remaining==0, otherwise go to SELECT.
- DONE: done=1 for this single cycle, then return to IDLE.
- Ignored inputs:
  - start and refill are ignored outside IDLE.
  - amount is sampled only on an accepted start.
- Selection is greedy with no backtracking. Example: 6 with inv5=1, inv2=3, inv1=0 pays 5, then sets short with remaining=1. This is the decided behaviour.
- Arithmetic: remaining and the inventories never underflow, because a decrement happens only after the guard check passes. Inventories are 4-bit and do not wrap; they are only loaded by refill or decremented.

## Timing
- Reset values: state IDLE; busy, done, short and all eject* = 0; remaining = 0; all inv* = 0.
- Reset asserted mid-operation clears every output immediately. The current coin is abandoned.
- All outputs come from registers or from decoding state/sel registers, with no combinational path from inputs.
- Let start be sampled at edge E0:
  - busy is high after E0, in SELECT.
  - The first eject goes high after E0+1.
- Each eject pulse lasts from entry to PULSE until the cycle after the PULSE_TICKS-th tick counted in PULSE.
- The per-coin overhead beyond tick pacing is 1 SELECT cycle. DONE adds 1 cycle.
- amount==0: done is high in the cycle after E0, busy is high for that one cycle only, and no eject is issued.
- A tick arriving in the same cycle as the PULSE entry edge is not counted. Counting starts in the first cycle the state is PULSE.

## Test plan
- Full payout: refill 3/3/3/3, then start with amount=18 → ejects 10, 5, 2, 1 in that order, each pulse lasting 2 ticks with a 1-tick gap. End state: remaining=0, short=0, done pulses once, inventories 2/2/2/2.
- Zero amount: start with amount=0 → done pulses one cycle after start, no eject asserted, busy high for exactly 1 cycle.
- Shortfall: refill 0/1/1/0, then start with 13 → ejects 5 then 2. End state: short=1, remaining=6, done pulses, inventories 0/0/0/0.
- Pacing: PULSE_TICKS=3, GAP_TICKS=2, tick every 5 cycles → each eject is high for exactly 3 counted ticks. Assert eject one-hot and verify gap length.
- Ignored inputs: start=40 issued while busy, and refill issued while busy → neither has any effect. Also refill and start in the same cycle in IDLE → inventories load, busy stays 0.
- Reset mid-pulse: drop rst_n while eject10 is high → eject10, busy, remaining and all inv* go to 0 immediately. After release, the FSM is in IDLE and accepts a new refill/start.

Source files
------------

// File: rtl/change_dispenser.sv
// change_dispenser
//
// Pays out a change amount greedily in coins of 10, 5, 2 and 1, drawing on a
// per-denomination inventory. Each coin is released as an eject pulse that
// lasts PULSE_TICKS tick strobes, followed by an idle gap of GAP_TICKS
// strobes. A shortfall is flagged when the inventory cannot cover the amount.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   tick                    one-cycle pacing strobe
//   start, amount           one-cycle request to pay amount (0..127)
//   refill, inv*_in         one-cycle load of all four inventories
//   busy                    high whenever the FSM is not idle
//   done                    one-cycle completion pulse
//   short                   last request could not be paid in full
//   remaining               amount still unpaid
//   eject10/5/2/1           coin release pulses, at most one high at a time
//   inv10/5/2/1             current inventory counts
//
// Handshake: start and refill are single-cycle strobes that are only acted on
// while idle (busy low); refill takes priority when both arrive together.
// done marks the end of every accepted start, including a zero amount.

module change_dispenser #(
    parameter int PULSE_TICKS = 2,
    parameter int GAP_TICKS   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       start,
    input  logic [6:0] amount,
    input  logic       refill,
    input  logic [3:0] inv10_in,
    input  logic [3:0] inv5_in,
    input  logic [3:0] inv2_in,
    input  logic [3:0] inv1_in,
    output logic       busy,
    output logic       done,
    output logic       short,
    output logic [6:0] remaining,
    output logic       eject10,
    output logic       eject5,
    output logic       eject2,
    output logic       eject1,
    output logic [3:0] inv10,
    output logic [3:0] inv5,
    output logic [3:0] inv2,
    output logic [3:0] inv1
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_PULSE,
        S_GAP,
        S_DONE
    } state_t;

    localparam int CMAX = (PULSE_TICKS > GAP_TICKS) ? PULSE_TICKS : GAP_TICKS;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_TICKS - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_TICKS - 1);

    // Denomination index: 0 -> 10, 1 -> 5, 2 -> 2, 3 -> 1.
    function automatic logic [6:0] coin_value(input logic [1:0] idx);
        case (idx)
            2'd0:    coin_value = 7'd10;
            2'd1:    coin_value = 7'd5;
            2'd2:    coin_value = 7'd2;
            default: coin_value = 7'd1;
        endcase
    endfunction

    state_t          state_q, state_d;
    logic [1:0]      sel_q, sel_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [6:0]      rem_q, rem_d;
    logic            short_q, short_d;
    logic [3:0][3:0] inv_q, inv_d;

    logic            found;
    logic [1:0]      pick;

    // Greedy pick: largest coin that fits the remainder and is in stock.
    always_comb begin
        found = 1'b1;
        pick  = 2'd0;
        if (rem_q >= 7'd10 && inv_q[0] != 4'd0) begin
            pick = 2'd0;
        end else if (rem_q >= 7'd5 && inv_q[1] != 4'd0) begin
            pick = 2'd1;
        end else if (rem_q >= 7'd2 && inv_q[2] != 4'd0) begin
            pick = 2'd2;
        end else if (rem_q != 7'd0 && inv_q[3] != 4'd0) begin
            pick = 2'd3;
        end else begin
            found = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sel_q   <= 2'd0;
            cnt_q   <= '0;
            rem_q   <= 7'd0;
            short_q <= 1'b0;
            inv_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            short_q <= short_d;
            inv_q   <= inv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        short_d = short_q;
        inv_d   = inv_q;
        case (state_q)
            S_IDLE: begin
                if (refill) begin
                    inv_d = {inv1_in, inv2_in, inv5_in, inv10_in};
                end else if (start) begin
                    rem_d   = amount;
                    short_d = 1'b0;
                    state_d = (amount == 7'd0) ? S_DONE : S_SELECT;
                end
            end
            S_SELECT: begin
                if (found) begin
                    sel_d       = pick;
                    inv_d[pick] = inv_q[pick] - 4'd1;
                    rem_d       = rem_q - coin_value(pick);
                    cnt_d       = '0;
                    state_d     = S_PULSE;
                end else begin
                    // remaining keeps the unpaid value for the host to see.
                    short_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_PULSE: begin
                if (tick) begin
                    if (cnt_q == PULSE_LAST) begin
                        cnt_d   = '0;
                        state_d = S_GAP;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_GAP: begin
                if (tick) begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d   = '0;
                        state_d = (rem_q == 7'd0) ? S_DONE : S_SELECT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign short     = short_q;
    assign remaining = rem_q;
    assign eject10   = (state_q == S_PULSE) && (sel_q == 2'd0);
    assign eject5    = (state_q == S_PULSE) && (sel_q == 2'd1);
    assign eject2    = (state_q == S_PULSE) && (sel_q == 2'd2);
    assign eject1    = (state_q == S_PULSE) && (sel_q == 2'd3);
    assign inv10     = inv_q[0];
    assign inv5      = inv_q[1];
    assign inv2      = inv_q[2];
    assign inv1      = inv_q[3];

endmodule

// File: tb/tb_change_dispenser.sv
// Testbench for change_dispenser: a default instance (2/1 tick pacing) with
// random ticks and random transactions, and a 3/2 instance with a periodic
// tick used to check pulse and gap lengths.

module tb_change_dispenser;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- stimulus / DUT signals ----------------
    logic       tick_a, start_a, refill_a;
    logic       tick_p, start_p, refill_p;
    logic [6:0] amount;
    logic [3:0] inv10_in, inv5_in, inv2_in, inv1_in;

    logic       busy_a, done_a, short_a, e10_a, e5_a, e2_a, e1_a;
    logic [6:0] rem_a;
    logic [3:0] i10_a, i5_a, i2_a, i1_a;
    logic       busy_p, done_p, short_p, e10_p, e5_p, e2_p, e1_p;
    logic [6:0] rem_p;
    logic [3:0] i10_p, i5_p, i2_p, i1_p;

    change_dispenser dut (
        .clk(clk), .rst_n(rst_n), .tick(tick_a), .start(start_a), .amount(amount),
        .refill(refill_a), .inv10_in(inv10_in), .inv5_in(inv5_in), .inv2_in(inv2_in),
        .inv1_in(inv1_in), .busy(busy_a), .done(done_a), .short(short_a),
        .remaining(rem_a), .eject10(e10_a), .eject5(e5_a), .eject2(e2_a), .eject1(e1_a),
        .inv10(i10_a), .inv5(i5_a), .inv2(i2_a), .inv1(i1_a)
    );

    change_dispenser #(.PULSE_TICKS(3), .GAP_TICKS(2)) dut_p (
        .clk(clk), .rst_n(rst_n), .tick(tick_p), .start(start_p), .amount(amount),
        .refill(refill_p), .inv10_in(inv10_in), .inv5_in(inv5_in), .inv2_in(inv2_in),
        .inv1_in(inv1_in), .busy(busy_p), .done(done_p), .short(short_p),
        .remaining(rem_p), .eject10(e10_p), .eject5(e5_p), .eject2(e2_p), .eject1(e1_p),
        .inv10(i10_p), .inv5(i5_p), .inv2(i2_p), .inv1(i1_p)
    );

    // ---------------- scoreboard state ----------------
    int n_vec  = 0;
    int n_miss = 0;

    logic [3:0] exp_q[$];      // expected coin values, in payout order
    int         m_inv[4];      // model inventory of the default instance
    int         e_inv[4];
    int         e_rem;
    bit         e_sh;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: greedy payout over coin values with plain arithmetic.
    task automatic greedy(input int amt, input int inv_in[4], output int inv_out[4],
                          output int rem, output bit sh);
        int val[4];
        val = '{10, 5, 2, 1};
        inv_out = inv_in;
        rem = amt;
        sh = 1'b0;
        exp_q.delete();
        while (rem > 0 && !sh) begin
            bit got;
            got = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (!got && val[k] <= rem && inv_out[k] > 0) begin
                    got = 1'b1;
                    inv_out[k]--;
                    rem -= val[k];
                    exp_q.push_back(4'(val[k]));
                end
            end
            if (!got) sh = 1'b1;
        end
    endtask

    function automatic logic [3:0] coin_of(input logic [3:0] ej);
        case (ej)
            4'b1000: coin_of = 4'd10;
            4'b0100: coin_of = 4'd5;
            4'b0010: coin_of = 4'd2;
            4'b0001: coin_of = 4'd1;
            4'b0000: coin_of = 4'd0;
            default: coin_of = 4'd15;
        endcase
    endfunction

    // ---------------- tick drivers ----------------
    initial begin
        tick_a = 1'b0;
        forever begin
            @(posedge clk); #1;
            tick_a = ($urandom_range(0, 2) == 0);
        end
    end

    initial begin
        tick_p = 1'b0;
        forever begin
            repeat (4) begin @(posedge clk); #1; tick_p = 1'b0; end
            @(posedge clk); #1; tick_p = 1'b1;
        end
    end

    // ---------------- output monitors ----------------
    logic [3:0] obs_a_q[$];
    int         ptk_a_q[$];
    int         done_cnt_a, bad_a, tk_a;
    logic [3:0] prev_a, c_a;

    logic [3:0] obs_p_q[$];
    int         ptk_p_q[$];
    int         gap_p_q[$];
    int         done_cnt_p, bad_p, tk_p, low_p;
    bit         seen_p;
    logic [3:0] prev_p, c_p;

    initial begin
        prev_a = 4'd0; done_cnt_a = 0; bad_a = 0; tk_a = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_a = 4'd0;
            end else begin
                c_a = coin_of({e10_a, e5_a, e2_a, e1_a});
                if (c_a == 4'd15) bad_a++;
                if (c_a != 4'd0 && prev_a == 4'd0) begin obs_a_q.push_back(c_a); tk_a = 0; end
                if (c_a != 4'd0 && tick_a) tk_a++;
                if (c_a == 4'd0 && prev_a != 4'd0) ptk_a_q.push_back(tk_a);
                if (done_a) done_cnt_a++;
                prev_a = c_a;
            end
        end
    end

    initial begin
        prev_p = 4'd0; done_cnt_p = 0; bad_p = 0; tk_p = 0; low_p = 0; seen_p = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n || !busy_p) begin
                prev_p = 4'd0;
                seen_p = 1'b0;
            end else begin
                c_p = coin_of({e10_p, e5_p, e2_p, e1_p});
                if (c_p == 4'd15) bad_p++;
                if (c_p != 4'd0 && prev_p == 4'd0) begin
                    obs_p_q.push_back(c_p);
                    if (seen_p) gap_p_q.push_back(low_p);
                    seen_p = 1'b1;
                    tk_p = 0;
                end
                if (c_p != 4'd0 && tick_p) tk_p++;
                if (c_p == 4'd0 && prev_p != 4'd0) ptk_p_q.push_back(tk_p);
                if (c_p == 4'd0 && seen_p) low_p++;
                if (c_p != 4'd0) low_p = 0;
                prev_p = c_p;
            end
            if (rst_n && done_p) done_cnt_p++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic refill_a_t(input int a, input int b, input int c, input int d);
        @(posedge clk); #1;
        inv10_in = 4'(a); inv5_in = 4'(b); inv2_in = 4'(c); inv1_in = 4'(d);
        refill_a = 1'b1;
        @(posedge clk); #1;
        refill_a = 1'b0;
        m_inv = '{a, b, c, d};
    endtask

    // Returns 1 ns after the edge that samples start (E0).
    task automatic start_a_t(input int amt);
        @(posedge clk); #1;
        start_a = 1'b1; amount = 7'(amt);
        @(posedge clk); #1;
        start_a = 1'b0;
    endtask

    task automatic prep_a(input int amt);
        greedy(amt, m_inv, e_inv, e_rem, e_sh);
        obs_a_q.delete(); ptk_a_q.delete();
        done_cnt_a = 0; bad_a = 0;
    endtask

    task automatic finish_a(input string tag);
        int budget;
        budget = 0;
        while (done_cnt_a == 0 && budget < 5000) begin @(negedge clk); budget++; end
        check({tag, ".done_seen"}, 32'(done_cnt_a != 0), 1);
        @(posedge clk); #1;
        check({tag, ".done_count"}, done_cnt_a, 1);
        check({tag, ".busy_after"}, busy_a, 0);
        check({tag, ".remaining"}, rem_a, e_rem);
        check({tag, ".short"}, short_a, e_sh);
        check({tag, ".inv10"}, i10_a, e_inv[0]);
        check({tag, ".inv5"}, i5_a, e_inv[1]);
        check({tag, ".inv2"}, i2_a, e_inv[2]);
        check({tag, ".inv1"}, i1_a, e_inv[3]);
        check({tag, ".onehot"}, bad_a, 0);
        check({tag, ".coin_count"}, obs_a_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_a_q.size(); i++)
            check($sformatf("%s.coin%0d", tag, i), obs_a_q[i], exp_q[i]);
        for (int i = 0; i < ptk_a_q.size(); i++)
            check($sformatf("%s.pulse_ticks%0d", tag, i), ptk_a_q[i], 2);
        m_inv = e_inv;
    endtask

    task automatic run_a(input int amt, input string tag);
        prep_a(amt);
        start_a_t(amt);
        check({tag, ".busy_e0"}, busy_a, 1);
        finish_a(tag);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int budget;
        int p_inv[4];
        int p_out[4];
        int p_rem;
        bit p_sh;

        rst_n = 1'b0;
        start_a = 1'b0; refill_a = 1'b0; start_p = 1'b0; refill_p = 1'b0;
        amount = 7'd0;
        inv10_in = 4'd0; inv5_in = 4'd0; inv2_in = 4'd0; inv1_in = 4'd0;
        m_inv = '{0, 0, 0, 0};
        repeat (3) @(posedge clk);
        #1;
        check("reset.busy", busy_a, 0);
        check("reset.done", done_a, 0);
        check("reset.short", short_a, 0);
        check("reset.remaining", rem_a, 0);
        check("reset.eject", {e10_a, e5_a, e2_a, e1_a}, 0);
        check("reset.inv", {i10_a, i5_a, i2_a, i1_a}, 0);
        rst_n = 1'b1;

        // Full payout: 18 from 3/3/3/3, first eject right after E0+1.
        refill_a_t(3, 3, 3, 3);
        prep_a(18);
        start_a_t(18);
        check("full.busy_e0", busy_a, 1);
        @(posedge clk); #1;
        check("full.eject10_e1", e10_a, 1);
        finish_a("full");

        // Zero amount: done one cycle after start, busy for that cycle only.
        prep_a(0);
        start_a_t(0);
        check("zero.done_e0", done_a, 1);
        check("zero.busy_e0", busy_a, 1);
        @(posedge clk); #1;
        check("zero.busy_e1", busy_a, 0);
        check("zero.done_e1", done_a, 0);
        finish_a("zero");

        // Shortfall: 13 from 0/1/1/0 pays 5 and 2, leaves 6.
        refill_a_t(0, 1, 1, 0);
        run_a(13, "short13");

        // Greedy without backtracking: 6 from 0/1/3/0 pays 5, leaves 1.
        refill_a_t(0, 1, 3, 0);
        run_a(6, "greedy6");

        // start and refill while busy are ignored.
        refill_a_t(3, 3, 3, 3);
        prep_a(17);
        start_a_t(17);
        repeat (3) @(posedge clk);
        #1;
        check("ignore.busy_before", busy_a, 1);
        start_a = 1'b1; amount = 7'd40; refill_a = 1'b1;
        inv10_in = 4'd15; inv5_in = 4'd15; inv2_in = 4'd15; inv1_in = 4'd15;
        @(posedge clk); #1;
        start_a = 1'b0; refill_a = 1'b0;
        finish_a("ignore");

        // refill and start together in idle: refill wins.
        @(posedge clk); #1;
        inv10_in = 4'd7; inv5_in = 4'd6; inv2_in = 4'd5; inv1_in = 4'd4;
        refill_a = 1'b1; start_a = 1'b1; amount = 7'd9;
        done_cnt_a = 0;
        @(posedge clk); #1;
        refill_a = 1'b0; start_a = 1'b0;
        check("both.busy0", busy_a, 0);
        repeat (3) @(posedge clk);
        #1;
        check("both.busy3", busy_a, 0);
        check("both.done_count", done_cnt_a, 0);
        check("both.inv", {i10_a, i5_a, i2_a, i1_a}, {4'd7, 4'd6, 4'd5, 4'd4});
        m_inv = '{7, 6, 5, 4};

        // Random transactions.
        for (int t = 0; t < 20; t++) begin
            if ($urandom_range(0, 2) == 0)
                refill_a_t($urandom_range(0, 15), $urandom_range(0, 15),
                           $urandom_range(0, 15), $urandom_range(0, 15));
            run_a($urandom_range(0, 127), $sformatf("rand%0d", t));
        end

        // Pacing instance: 8 from 3/3/3/3 with tick every 5 cycles.
        @(posedge clk); #1;
        inv10_in = 4'd3; inv5_in = 4'd3; inv2_in = 4'd3; inv1_in = 4'd3;
        refill_p = 1'b1;
        @(posedge clk); #1;
        refill_p = 1'b0;
        p_inv = '{3, 3, 3, 3};
        greedy(8, p_inv, p_out, p_rem, p_sh);
        obs_p_q.delete(); ptk_p_q.delete(); gap_p_q.delete();
        done_cnt_p = 0; bad_p = 0;
        start_p = 1'b1; amount = 7'd8;
        @(posedge clk); #1;
        start_p = 1'b0;
        budget = 0;
        while (done_cnt_p == 0 && budget < 5000) begin @(negedge clk); budget++; end
        check("pace.done_seen", 32'(done_cnt_p != 0), 1);
        @(posedge clk); #1;
        check("pace.remaining", rem_p, p_rem);
        check("pace.short", short_p, p_sh);
        check("pace.onehot", bad_p, 0);
        check("pace.coin_count", obs_p_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_p_q.size(); i++)
            check($sformatf("pace.coin%0d", i), obs_p_q[i], exp_q[i]);
        check("pace.pulse_count", ptk_p_q.size(), exp_q.size());
        for (int i = 0; i < ptk_p_q.size(); i++)
            check($sformatf("pace.pulse_ticks%0d", i), ptk_p_q[i], 3);
        // Low time between coins: GAP_TICKS periods plus the SELECT cycle.
        check("pace.gap_count", gap_p_q.size(), exp_q.size() - 1);
        for (int i = 0; i < gap_p_q.size(); i++)
            check($sformatf("pace.gap_cycles%0d", i), gap_p_q[i], 2 * 5 + 1);

        // Reset in the middle of an eject10 pulse.
        refill_a_t(3, 3, 3, 3);
        prep_a(10);
        start_a_t(10);
        budget = 0;
        while (!e10_a && budget < 200) begin @(negedge clk); budget++; end
        check("rst.eject10_seen", e10_a, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst.eject10", e10_a, 0);
        check("rst.busy", busy_a, 0);
        check("rst.remaining", rem_a, 0);
        check("rst.inv", {i10_a, i5_a, i2_a, i1_a}, 0);
        m_inv = '{0, 0, 0, 0};
        @(posedge clk); #1;
        rst_n = 1'b1;
        refill_a_t(1, 0, 0, 0);
        run_a(10, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
